sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO. It is the successor to the team's fixed 8-bit FIFO and is generalised in data width and depth. It adds a fill count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and an optional first-word-fall-through (FWFT) read mode. It is the standard single-clock buffer between producer and consumer stages.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_mem_2p.sv | 26 ++
 rtl/sync_fifo_param.sv | 128 ++++++++++++
 tb/tb_sync_fifo_param.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

  // Default distance of the almost-full threshold below DEPTH.
  localparam int unsigned AF_OFFSET_DEFAULT = 2;
  localparam int unsigned AE_LEVEL_DEFAULT  = 2;

  // Bit positions of the sticky error flags when mapped into a status register.
  localparam int unsigned ERR_OVF_BIT = 0;
  localparam int unsigned ERR_UDF_BIT = 1;
  localparam int unsigned ERR_W       = 2;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_mem_2p #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, threshold flags, sticky
// error flags and optional first-word-fall-through read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - AF_OFFSET_DEFAULT,
  parameter int unsigned AE_LEVEL = AE_LEVEL_DEFAULT,
  parameter int unsigned FWFT     = 0,
  localparam int unsigned CNT_W   = fifo_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              f_empty,
  output logic              f_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if ((AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_levels
    $fatal(1, "sync_fifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              af_q, af_d, ae_q, ae_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_ok, wr_ok;

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Acceptance, next-state and flag derivation from the next count.
  always_comb begin
    rd_ok    = r_en & ~empty_q;
    wr_ok    = w_en & (~full_q | rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    err_d    = clr_err ? '0 : err_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      data_d   = mem_rdata;
    end
    if (w_en & ~wr_ok) begin
      err_d[ERR_OVF_BIT] = 1'b1;
    end
    if (r_en & ~rd_ok) begin
      err_d[ERR_UDF_BIT] = 1'b1;
    end

    count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    empty_d = (count_d == '0);
    full_d  = (32'(count_d) == DEPTH);
    af_d    = (32'(count_d) >= AF_LEVEL);
    ae_d    = (32'(count_d) <= AE_LEVEL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      err_q    <= err_d;
    end
  end

  // FWFT exposes the head word directly; the registered copy covers the empty case.
  if (FWFT != 0) begin : g_fwft
    assign data_out = empty_q ? data_q : mem_rdata;
  end else begin : g_reg_read
    assign data_out = data_q;
  end

  assign f_empty      = empty_q;
  assign f_full       = full_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = err_q[ERR_OVF_BIT];
  assign underflow    = err_q[ERR_UDF_BIT];

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: registered-read and FWFT instances share stimulus.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst, w_en, r_en, clr_err;
  logic [7:0] data_in;

  logic [7:0] dout0, dout1;
  logic       emp0, full0, af0, ae0, ovf0, udf0;
  logic       emp1, full1, af1, ae1, ovf1, udf1;
  logic [3:0] cnt0, cnt1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .clr_err(clr_err), .data_out(dout0), .f_empty(emp0), .f_full(full0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .clr_err(clr_err), .data_out(dout1), .f_empty(emp1), .f_full(full1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(udf1)
  );

  // Status word: {count, full, empty, almost_full, almost_empty, overflow, underflow}.
  function automatic logic [9:0] st0();
    return {cnt0, full0, emp0, af0, ae0, ovf0, udf0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; data_in = 8'h00;
    tick();
    rst = 1'b0;
    tests_run++;
    if (st0() !== 10'b0000_0_1_0_1_0_0) begin
      tests_failed++;
      $display("FAIL reset_status got %b exp %b", st0(), 10'b0000_0_1_0_1_0_0);
    end
    tests_run++;
    if (dout0 !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_dout got %h exp 00", dout0);
    end
  endtask

  task automatic test_basic();
    logic [7:0] vals [3];
    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1; data_in = vals[i];
      tick();
    end
    idle();
    tests_run++;
    if (cnt0 !== 4'd3) begin
      tests_failed++;
      $display("FAIL basic_count got %0d exp 3", cnt0);
    end
    for (int i = 0; i < 3; i++) begin
      r_en = 1'b1;
      tick();
      tests_run++;
      if (dout0 !== vals[i] || cnt0 !== 4'(2 - i)) begin
        tests_failed++;
        $display("FAIL basic_read%0d got %h/%0d exp %h/%0d", i, dout0, cnt0, vals[i], 2 - i);
      end
    end
    idle();
    tests_run++;
    if (st0() !== 10'b0000_0_1_0_1_0_0) begin
      tests_failed++;
      $display("FAIL basic_empty got %b exp %b", st0(), 10'b0000_0_1_0_1_0_0);
    end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; data_in = 8'(i);
      tick();
      tests_run++;
      if (af0 !== (i + 1 >= 6) || ae0 !== (i + 1 <= 2)) begin
        tests_failed++;
        $display("FAIL fill_thresh%0d got af=%b ae=%b exp af=%b ae=%b",
                 i, af0, ae0, (i + 1 >= 6), (i + 1 <= 2));
      end
    end
    tests_run++;
    if (st0() !== 10'b1000_1_0_1_0_0_0) begin
      tests_failed++;
      $display("FAIL full_status got %b exp %b", st0(), 10'b1000_1_0_1_0_0_0);
    end
    data_in = 8'h08;
    tick();
    idle();
    tests_run++;
    if (st0() !== 10'b1000_1_0_1_0_1_0) begin
      tests_failed++;
      $display("FAIL overflow_status got %b exp %b", st0(), 10'b1000_1_0_1_0_1_0);
    end
    for (int i = 0; i < 8; i++) begin
      r_en = 1'b1;
      tick();
      tests_run++;
      if (dout0 !== 8'(i)) begin
        tests_failed++;
        $display("FAIL drain%0d got %h exp %h", i, dout0, 8'(i));
      end
    end
    r_en = 1'b0; clr_err = 1'b1;
    tick();
    idle();
    tests_run++;
    if (st0() !== 10'b0000_0_1_0_1_0_0) begin
      tests_failed++;
      $display("FAIL drained_clr got %b exp %b", st0(), 10'b0000_0_1_0_1_0_0);
    end
  endtask

  task automatic test_back_to_back_full();
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; data_in = 8'(i);
      tick();
    end
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h55;
    tick();
    idle();
    tests_run++;
    if (st0() !== 10'b1000_1_0_1_0_0_0 || dout0 !== 8'h00) begin
      tests_failed++;
      $display("FAIL full_rw got %b/%h exp %b/00", st0(), dout0, 10'b1000_1_0_1_0_0_0);
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_d;
      exp_d = (i == 7) ? 8'h55 : 8'(i + 1);
      r_en = 1'b1;
      tick();
      tests_run++;
      if (dout0 !== exp_d) begin
        tests_failed++;
        $display("FAIL wrap_drain%0d got %h exp %h", i, dout0, exp_d);
      end
    end
    idle();
  endtask

  task automatic test_underflow();
    r_en = 1'b1;
    tick();
    idle();
    tests_run++;
    if (udf0 !== 1'b1 || cnt0 !== 4'd0 || ovf0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow_set got udf=%b cnt=%0d ovf=%b exp 1/0/0", udf0, cnt0, ovf0);
    end
    clr_err = 1'b1;
    tick();
    idle();
    tests_run++;
    if (udf0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow_clr got %b exp 0", udf0);
    end
    r_en = 1'b1; w_en = 1'b1; data_in = 8'h77;
    tick();
    idle();
    tests_run++;
    if (cnt0 !== 4'd1 || udf0 !== 1'b1 || udf1 !== 1'b1 || emp0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_rw got cnt=%0d udf=%b/%b emp=%b exp 1/1/1/0", cnt0, udf0, udf1, emp0);
    end
    r_en = 1'b1;
    tick();
    idle();
    tests_run++;
    if (dout0 !== 8'h77 || emp0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_rw_data got %h emp=%b exp 77/1", dout0, emp0);
    end
    // A new error coinciding with clr_err keeps the flag set.
    r_en = 1'b1; clr_err = 1'b1;
    tick();
    idle();
    tests_run++;
    if (udf0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL set_wins got %b exp 1", udf0);
    end
    clr_err = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_fwft();
    w_en = 1'b1; data_in = 8'h3C;
    tick();
    idle();
    tests_run++;
    if (dout1 !== 8'h3C || cnt1 !== 4'd1 || emp1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwft_first got %h cnt=%0d emp=%b exp 3c/1/0", dout1, cnt1, emp1);
    end
    w_en = 1'b1; data_in = 8'h4D;
    tick();
    idle();
    tests_run++;
    if (dout1 !== 8'h3C || cnt1 !== 4'd2) begin
      tests_failed++;
      $display("FAIL fwft_hold got %h cnt=%0d exp 3c/2", dout1, cnt1);
    end
    r_en = 1'b1;
    tick();
    idle();
    tests_run++;
    if (dout1 !== 8'h4D || cnt1 !== 4'd1) begin
      tests_failed++;
      $display("FAIL fwft_advance got %h cnt=%0d exp 4d/1", dout1, cnt1);
    end
    tests_run++;
    if (dout0 !== 8'h3C) begin
      tests_failed++;
      $display("FAIL reg_mode_read got %h exp 3c", dout0);
    end
    r_en = 1'b1;
    tick();
    idle();
    tests_run++;
    if (emp1 !== 1'b1 || udf1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwft_drain got emp=%b udf=%b exp 1/0", emp1, udf1);
    end
  endtask

  task automatic test_mid_reset();
    r_en = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      w_en = 1'b1; data_in = 8'(8'h11 + i);
      tick();
    end
    idle();
    tests_run++;
    if (st0() !== 10'b0101_0_0_0_0_0_1) begin
      tests_failed++;
      $display("FAIL pre_reset got %b exp %b", st0(), 10'b0101_0_0_0_0_0_1);
    end
    rst = 1'b1; w_en = 1'b1; r_en = 1'b1; data_in = 8'hEE;
    tick();
    idle();
    tests_run++;
    if (st0() !== 10'b0000_0_1_0_1_0_0 || dout0 !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_reset got %b/%h exp %b/00", st0(), dout0, 10'b0000_0_1_0_1_0_0);
    end
    w_en = 1'b1; data_in = 8'h9E;
    tick();
    idle();
    tests_run++;
    if (dout1 !== 8'h9E || cnt0 !== 4'd1) begin
      tests_failed++;
      $display("FAIL post_reset_fwft got %h cnt=%0d exp 9e/1", dout1, cnt0);
    end
    r_en = 1'b1;
    tick();
    idle();
    tests_run++;
    if (dout0 !== 8'h9E || emp0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_read got %h emp=%b exp 9e/1", dout0, emp0);
    end
  endtask

  initial begin
    idle();
    data_in = 8'h00;
    test_reset();
    test_basic();
    test_full_overflow();
    test_back_to_back_full();
    test_underflow();
    test_fwft();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
